// File: rtl/macro_io_arbiter.sv
// Output-stage arbiter: one experiment macro at a time owns the wishbone response path and the pads.
// Ownership is chosen through a local CTRL CSR and handed over break-before-make through a tristate guard window.
module macro_io_arbiter #(
    parameter int          NUM_MACROS   = 4,
    parameter int          IO_W         = 38,
    parameter int          GUARD_CYCLES = 4,
    parameter int          ACK_TIMEOUT  = 255,
    parameter logic [31:0] CSR_BASE     = 32'h3000_0000
) (
    input  logic                       wb_clk_i,
    input  logic                       wb_rst_ni,
    input  logic                       wbs_stb_i,
    input  logic                       wbs_cyc_i,
    input  logic                       wbs_we_i,
    input  logic [3:0]                 wbs_sel_i,
    input  logic [31:0]                wbs_adr_i,
    input  logic [31:0]                wbs_dat_i,
    output logic                       wbs_ack_o,
    output logic [31:0]                wbs_dat_o,
    input  logic [NUM_MACROS-1:0]      m_ack_i,
    input  logic [32*NUM_MACROS-1:0]   m_dat_i,
    input  logic [IO_W*NUM_MACROS-1:0] m_io_out_i,
    input  logic [IO_W*NUM_MACROS-1:0] m_io_oeb_i,
    output logic [NUM_MACROS-1:0]      m_active_o,
    output logic [NUM_MACROS-1:0]      m_stb_o,
    output logic [IO_W-1:0]            io_out,
    output logic [IO_W-1:0]            io_oeb
);

    localparam int OW = $clog2(NUM_MACROS);
    localparam int GW = $clog2(GUARD_CYCLES + 1);
    localparam int TW = $clog2(ACK_TIMEOUT + 1);
    localparam logic [NUM_MACROS-1:0] LSB = {{(NUM_MACROS-1){1'b0}}, 1'b1};
    localparam logic [29:0] CTRL_WA = CSR_BASE[31:2];
    localparam logic [29:0] STAT_WA = CSR_BASE[31:2] + 30'd1;
    localparam logic [31:0] ERR_DATA = 32'hDEAD_BEEF;

    typedef enum logic [1:0] {S_OFF = 2'd0, S_GUARD = 2'd1, S_ON = 2'd2} own_state_t;
    typedef enum logic [1:0] {B_IDLE, B_FWD, B_RESP} bus_state_t;

    own_state_t     state;
    bus_state_t     bstate;
    logic [OW-1:0]  owner;
    logic [OW-1:0]  fwd_idx;
    logic [GW-1:0]  gcnt;
    logic [TW-1:0]  tmr;
    logic [2:0]     ctrl_sel;
    logic           ctrl_en;
    logic           ctrl_upd;
    logic           timeout_err;
    logic           badsel_err;

    logic           req;
    logic           hit_ctrl;
    logic           hit_stat;
    logic           wsel_ok;
    logic           leave_on;
    logic [31:0]    ctrl_word;
    logic [31:0]    status_word;
    logic [IO_W-1:0] own_out;
    logic [IO_W-1:0] own_oeb;
    logic [31:0]    fwd_dat;
    logic           fwd_ack;
    logic           unused_bits;

    assign req         = wbs_cyc_i & wbs_stb_i;
    assign hit_ctrl    = wbs_adr_i[31:2] == CTRL_WA;
    assign hit_stat    = wbs_adr_i[31:2] == STAT_WA;
    assign wsel_ok     = int'(wbs_dat_i[2:0]) < NUM_MACROS;
    assign ctrl_word   = {23'd0, ctrl_en, 5'd0, ctrl_sel};
    assign status_word = {22'd0, badsel_err, timeout_err, 2'd0, state, 1'b0, 3'(owner)};
    assign unused_bits = ^{wbs_sel_i, wbs_dat_i[31:10], wbs_dat_i[7:3], wbs_adr_i[1:0]};

    // An applied CTRL update that moves us out of ON must tristate the pads on the same edge.
    assign leave_on = ctrl_upd && (!ctrl_en || ctrl_sel != 3'(owner));

    always_comb begin
        own_out = '0;
        own_oeb = '1;
        fwd_dat = '0;
        fwd_ack = 1'b0;
        for (int k = 0; k < NUM_MACROS; k++) begin
            if (int'(owner) == k) begin
                own_out = m_io_out_i[k*IO_W +: IO_W];
                own_oeb = m_io_oeb_i[k*IO_W +: IO_W];
            end
            if (int'(fwd_idx) == k) begin
                fwd_dat = m_dat_i[k*32 +: 32];
                fwd_ack = m_ack_i[k];
            end
        end
    end

    // Ownership FSM; CTRL updates arrive one cycle after the write so they land after its ack.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state      <= S_OFF;
            owner      <= '0;
            gcnt       <= '0;
            m_active_o <= '0;
            io_out     <= '0;
            io_oeb     <= '1;
        end else begin
            if (state == S_ON && !leave_on) begin
                io_out <= own_out;
                io_oeb <= own_oeb;
            end else begin
                io_out <= '0;
                io_oeb <= '1;
            end
            case (state)
                S_OFF: begin
                    if (ctrl_upd && ctrl_en) begin
                        state <= S_GUARD;
                        gcnt  <= '0;
                    end
                end
                S_GUARD: begin
                    if (ctrl_upd) begin
                        if (ctrl_en) gcnt  <= '0;
                        else         state <= S_OFF;
                    end else if (gcnt == GW'(GUARD_CYCLES - 1)) begin
                        state      <= S_ON;
                        owner      <= ctrl_sel[OW-1:0];
                        m_active_o <= LSB << ctrl_sel[OW-1:0];
                    end else begin
                        gcnt <= gcnt + 1'b1;
                    end
                end
                S_ON: begin
                    if (leave_on) begin
                        state      <= ctrl_en ? S_GUARD : S_OFF;
                        gcnt       <= '0;
                        m_active_o <= '0;
                    end
                end
                default: begin
                    state      <= S_OFF;
                    m_active_o <= '0;
                end
            endcase
        end
    end

    // Bus FSM: local CSRs, forwarding to the owner, and error/timeout responses.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            bstate      <= B_IDLE;
            wbs_ack_o   <= 1'b0;
            wbs_dat_o   <= '0;
            m_stb_o     <= '0;
            fwd_idx     <= '0;
            tmr         <= '0;
            ctrl_sel    <= '0;
            ctrl_en     <= 1'b0;
            ctrl_upd    <= 1'b0;
            timeout_err <= 1'b0;
            badsel_err  <= 1'b0;
        end else begin
            ctrl_upd <= 1'b0;
            case (bstate)
                B_IDLE: begin
                    if (req) begin
                        if (hit_ctrl || hit_stat) begin
                            wbs_ack_o <= 1'b1;
                            wbs_dat_o <= hit_ctrl ? ctrl_word : status_word;
                            bstate    <= B_RESP;
                            if (wbs_we_i && hit_ctrl) begin
                                if (wsel_ok) begin
                                    ctrl_sel <= wbs_dat_i[2:0];
                                    ctrl_en  <= wbs_dat_i[8];
                                    ctrl_upd <= 1'b1;
                                end else begin
                                    badsel_err <= 1'b1;
                                end
                            end
                            if (wbs_we_i && hit_stat) begin
                                if (wbs_dat_i[8]) timeout_err <= 1'b0;
                                if (wbs_dat_i[9]) badsel_err  <= 1'b0;
                            end
                        end else if (state == S_ON) begin
                            m_stb_o <= LSB << owner;
                            fwd_idx <= owner;
                            tmr     <= '0;
                            bstate  <= B_FWD;
                        end else begin
                            wbs_ack_o <= 1'b1;
                            wbs_dat_o <= ERR_DATA;
                            bstate    <= B_RESP;
                        end
                    end
                end
                B_FWD: begin
                    if (!wbs_cyc_i) begin
                        m_stb_o <= '0;
                        bstate  <= B_IDLE;
                    end else if (fwd_ack) begin
                        m_stb_o   <= '0;
                        wbs_ack_o <= 1'b1;
                        wbs_dat_o <= fwd_dat;
                        bstate    <= B_RESP;
                    end else if (tmr == TW'(ACK_TIMEOUT - 1)) begin
                        m_stb_o     <= '0;
                        wbs_ack_o   <= 1'b1;
                        wbs_dat_o   <= ERR_DATA;
                        timeout_err <= 1'b1;
                        bstate      <= B_RESP;
                    end else begin
                        tmr <= tmr + 1'b1;
                    end
                end
                B_RESP: begin
                    wbs_ack_o <= 1'b0;
                    bstate    <= B_IDLE;
                end
                default: begin
                    wbs_ack_o <= 1'b0;
                    m_stb_o   <= '0;
                    bstate    <= B_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_macro_io_arbiter.sv
// Directed bench for macro_io_arbiter: CSR vector table plus hand sequences for guard, forwarding,
// timeout, abort, bad select and reset-in-guard.
module tb_macro_io_arbiter;

    localparam int NM  = 4;
    localparam int IOW = 38;
    localparam int GC  = 4;
    localparam int TO  = 255;
    localparam logic [31:0] CTRL_A = 32'h3000_0000;
    localparam logic [31:0] STAT_A = 32'h3000_0004;
    localparam logic [31:0] MISS_A = 32'h3000_0100;
    localparam logic [IOW-1:0] ALL1 = '1;
    localparam logic [IOW-1:0] ALL0 = '0;

    logic              wb_clk_i = 1'b0;
    logic              wb_rst_ni = 1'b0;
    logic              wbs_stb_i = 1'b0, wbs_cyc_i = 1'b0, wbs_we_i = 1'b0;
    logic [3:0]        wbs_sel_i = 4'hF;
    logic [31:0]       wbs_adr_i = '0, wbs_dat_i = '0;
    logic              wbs_ack_o;
    logic [31:0]       wbs_dat_o;
    logic [NM-1:0]     m_ack_i = '0;
    logic [32*NM-1:0]  m_dat_i = '0;
    logic [IOW*NM-1:0] m_io_out_i = '0, m_io_oeb_i = '0;
    logic [NM-1:0]     m_active_o, m_stb_o;
    logic [IOW-1:0]    io_out, io_oeb;

    logic [IOW-1:0] out_pat [NM];
    logic [IOW-1:0] oeb_pat [NM];
    logic [31:0]    dat_pat [NM];

    int n_chk = 0;
    int n_fail = 0;

    macro_io_arbiter #(.NUM_MACROS(NM), .IO_W(IOW), .GUARD_CYCLES(GC), .ACK_TIMEOUT(TO)) dut (
        .wb_clk_i(wb_clk_i), .wb_rst_ni(wb_rst_ni),
        .wbs_stb_i(wbs_stb_i), .wbs_cyc_i(wbs_cyc_i), .wbs_we_i(wbs_we_i),
        .wbs_sel_i(wbs_sel_i), .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i),
        .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
        .m_ack_i(m_ack_i), .m_dat_i(m_dat_i),
        .m_io_out_i(m_io_out_i), .m_io_oeb_i(m_io_oeb_i),
        .m_active_o(m_active_o), .m_stb_o(m_stb_o),
        .io_out(io_out), .io_oeb(io_oeb)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    typedef struct {
        bit          we;
        logic [31:0] adr;
        logic [31:0] wd;
        bit          chk;
        logic [31:0] exp;
    } vec_t;

    localparam int NV = 13;
    vec_t tbl [NV];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge wb_clk_i);
        #1;
    endtask

    // One host transfer; returns read data and number of edges until ack (bounded).
    task automatic wb_xfer(input bit we, input logic [31:0] adr, input logic [31:0] wd,
                           output logic [31:0] rd, output int nc);
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = we;
        wbs_adr_i = adr;  wbs_dat_i = wd;
        nc = 0;
        rd = '0;
        for (int i = 0; i < 1000; i++) begin
            tick();
            nc++;
            if (wbs_ack_o) break;
        end
        rd = wbs_dat_o;
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
    endtask

    initial begin
        logic [31:0] rd;
        int nc;

        for (int k = 0; k < NM; k++) begin
            out_pat[k] = 38'h15_5555_5550 + 38'(k);
            oeb_pat[k] = 38'h0F_0F0F_0F00 | 38'(k);
            dat_pat[k] = 32'hC0DE_0000 + 32'(k);
            m_io_out_i[k*IOW +: IOW] = out_pat[k];
            m_io_oeb_i[k*IOW +: IOW] = oeb_pat[k];
            m_dat_i[k*32 +: 32]      = dat_pat[k];
        end

        tbl[0]  = '{1'b0, STAT_A, 32'h0,   1'b1, 32'h0000_0000};
        tbl[1]  = '{1'b0, CTRL_A, 32'h0,   1'b1, 32'h0000_0000};
        tbl[2]  = '{1'b0, MISS_A, 32'h0,   1'b1, 32'hDEAD_BEEF};
        tbl[3]  = '{1'b1, CTRL_A, 32'h107, 1'b0, 32'h0};
        tbl[4]  = '{1'b0, STAT_A, 32'h0,   1'b1, 32'h0000_0200};
        tbl[5]  = '{1'b0, CTRL_A, 32'h0,   1'b1, 32'h0000_0000};
        tbl[6]  = '{1'b1, CTRL_A, 32'h104, 1'b0, 32'h0};
        tbl[7]  = '{1'b0, CTRL_A, 32'h0,   1'b1, 32'h0000_0000};
        tbl[8]  = '{1'b1, STAT_A, 32'h200, 1'b0, 32'h0};
        tbl[9]  = '{1'b0, STAT_A, 32'h0,   1'b1, 32'h0000_0000};
        tbl[10] = '{1'b1, CTRL_A, 32'h002, 1'b0, 32'h0};
        tbl[11] = '{1'b0, CTRL_A, 32'h0,   1'b1, 32'h0000_0002};
        tbl[12] = '{1'b0, STAT_A, 32'h0,   1'b1, 32'h0000_0000};

        // Reset values
        repeat (3) tick();
        chk("rst_oeb", io_oeb, ALL1);
        chk("rst_out", io_out, ALL0);
        chk("rst_active", m_active_o, 0);
        chk("rst_stb", m_stb_o, 0);
        chk("rst_ack", wbs_ack_o, 0);
        chk("rst_dat", wbs_dat_o, 0);
        wb_rst_ni = 1'b1;
        tick();

        // CSR / not-owned table, all single-cycle responses
        for (int i = 0; i < NV; i++) begin
            wb_xfer(tbl[i].we, tbl[i].adr, tbl[i].wd, rd, nc);
            chk($sformatf("vec%0d_lat", i), nc, 1);
            if (tbl[i].chk) chk($sformatf("vec%0d_dat", i), rd, tbl[i].exp);
            tick();
            chk($sformatf("vec%0d_ackdrop", i), wbs_ack_o, 0);
            chk($sformatf("vec%0d_active", i), m_active_o, 0);
        end

        // Enable macro 1: guard window then ownership
        wb_xfer(1'b1, CTRL_A, 32'h101, rd, nc);
        chk("en1_lat", nc, 1);
        for (int i = 1; i <= GC; i++) begin
            tick();
            chk($sformatf("guard1_active_c%0d", i), m_active_o, 0);
            chk($sformatf("guard1_oeb_c%0d", i), io_oeb, ALL1);
        end
        tick();
        chk("on1_active", m_active_o, 4'b0010);
        chk("on1_oeb_first", io_oeb, ALL1);
        tick();
        chk("on1_out", io_out, out_pat[1]);
        chk("on1_oeb", io_oeb, oeb_pat[1]);
        wb_xfer(1'b0, STAT_A, 32'h0, rd, nc);
        chk("on1_status", rd, 32'h21);
        tick();

        // Forward read, non-owner ack ignored, owner ack on third stb cycle
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b0; wbs_adr_i = MISS_A;
        tick();
        chk("fwd_stb", m_stb_o, 4'b0010);
        chk("fwd_noack0", wbs_ack_o, 0);
        m_ack_i = 4'b0001;
        tick();
        chk("fwd_nonowner_ack", wbs_ack_o, 0);
        chk("fwd_stb_hold", m_stb_o, 4'b0010);
        m_ack_i = 4'b0000;
        tick();
        m_ack_i = 4'b0010;
        tick();
        chk("fwd_ack", wbs_ack_o, 1);
        chk("fwd_dat", wbs_dat_o, dat_pat[1]);
        chk("fwd_stb_drop", m_stb_o, 0);
        m_ack_i = 4'b0000;
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
        tick();
        chk("fwd_ack_once", wbs_ack_o, 0);
        chk("fwd_dat_hold", wbs_dat_o, dat_pat[1]);

        // Owner never acks -> timeout response
        wb_xfer(1'b0, MISS_A, 32'h0, rd, nc);
        chk("to_lat", nc, TO + 1);
        chk("to_dat", rd, 32'hDEAD_BEEF);
        tick();
        wb_xfer(1'b0, STAT_A, 32'h0, rd, nc);
        chk("to_status", rd, 32'h121);
        tick();
        wb_xfer(1'b1, STAT_A, 32'h100, rd, nc);
        tick();
        wb_xfer(1'b0, STAT_A, 32'h0, rd, nc);
        chk("to_w1c", rd, 32'h21);
        tick();

        // Host drops cyc mid-forward: abort without ack
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_adr_i = MISS_A;
        tick();
        chk("abort_stb", m_stb_o, 4'b0010);
        tick();
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
        tick();
        chk("abort_stb_drop", m_stb_o, 0);
        chk("abort_noack0", wbs_ack_o, 0);
        tick();
        chk("abort_noack1", wbs_ack_o, 0);
        wb_xfer(1'b0, STAT_A, 32'h0, rd, nc);
        chk("abort_idle_lat", nc, 1);
        chk("abort_status", rd, 32'h21);
        tick();

        // Bad select while ON leaves owner and state alone
        wb_xfer(1'b1, CTRL_A, 32'h107, rd, nc);
        tick();
        wb_xfer(1'b0, STAT_A, 32'h0, rd, nc);
        chk("badsel_on_status", rd, 32'h221);
        tick();
        chk("badsel_on_active", m_active_o, 4'b0010);
        wb_xfer(1'b1, STAT_A, 32'h200, rd, nc);
        tick();

        // Same-sel rewrite is a no-op
        wb_xfer(1'b1, CTRL_A, 32'h101, rd, nc);
        for (int i = 1; i <= 3; i++) begin
            tick();
            chk($sformatf("same_active_c%0d", i), m_active_o, 4'b0010);
            chk($sformatf("same_oeb_c%0d", i), io_oeb, oeb_pat[1]);
        end

        // Switch 1->3, then 3->2 mid-guard restarts the guard
        wb_xfer(1'b1, CTRL_A, 32'h103, rd, nc);
        tick();
        chk("sw_break_active", m_active_o, 0);
        chk("sw_break_oeb", io_oeb, ALL1);
        wb_xfer(1'b1, CTRL_A, 32'h102, rd, nc);
        chk("sw_lat", nc, 1);
        for (int i = 1; i <= GC; i++) begin
            tick();
            chk($sformatf("sw_guard_c%0d", i), m_active_o, 0);
        end
        tick();
        chk("sw_on2_active", m_active_o, 4'b0100);
        tick();
        chk("sw_on2_out", io_out, out_pat[2]);

        // Switch back toward 1, then reset during GUARD
        wb_xfer(1'b1, CTRL_A, 32'h101, rd, nc);
        tick();
        tick();
        #2 wb_rst_ni = 1'b0;
        #1;
        chk("rstg_active", m_active_o, 0);
        chk("rstg_oeb", io_oeb, ALL1);
        chk("rstg_out", io_out, ALL0);
        chk("rstg_ack", wbs_ack_o, 0);
        tick();
        wb_rst_ni = 1'b1;
        tick();
        wb_xfer(1'b0, STAT_A, 32'h0, rd, nc);
        chk("rstg_status", rd, 32'h0);
        tick();
        wb_xfer(1'b0, CTRL_A, 32'h0, rd, nc);
        chk("rstg_ctrl", rd, 32'h0);
        repeat (GC + 2) tick();
        chk("rstg_stays_off", m_active_o, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
